washer_sequencer: RTL
=====================

// Module: washer_sequencer
// PURPOSE
//  Wash-program controller that drives the shared phase timer ("counter": start in, done out)
//  and consumes its done pulse to step through fill/wash/drain/rinse/spin.
//  Sits between the front-panel inputs and the actuator drivers. It owns the timer's start line.
//  All phase durations are whole multiples of one timer period (T = timer COUNT_MAX clocks).
// PARAMETERS
//  FILL_UNITS   1  timer periods per FILL phase (1..255)
//  WASH_UNITS   3  timer periods per WASH phase (1..255)
//  RINSE_UNITS  2  timer periods per RINSE phase (1..255)
//  DRAIN_UNITS  1  timer periods per DRAIN phase (1..255)
//  SPIN_UNITS   2  timer periods per SPIN phase (1..255)
//  RINSES       1  number of FILL/RINSE/DRAIN rinse passes after the wash (0..15)
// PORTS
//  clk          in   1  clock
//  rstn         in   1  reset, asynchronous, active-low
//  start_btn    in   1  level; sampled in IDLE only, starts a program
//  cancel       in   1  level; aborts the running program
//  timer_done   in   1  done from phase timer
//  timer_start  out  1  start/enable to phase timer
//  valve_fill   out  1  water inlet valve (FILL)
//  motor_wash   out  1  agitation motor (WASH, RINSE)
//  motor_spin   out  1  spin motor (SPIN)
//  pump_drain   out  1  drain pump (DRAIN, FLUSH)
//  door_lock    out  1  high in every state except IDLE
//  busy         out  1  high in every state except IDLE
//  cycle_done   out  1  1-clk pulse on normal program completion
//  aborted      out  1  1-clk pulse when a cancelled program reaches IDLE
//  state        out  4  encoded state: IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 FLUSH=7 PAUSE=8
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, all outputs 0, unit and rinse counters 0.
//  - tick = timer_done & start_q. start_q is timer_start delayed 1 clk. This masks the stale sticky
//    done that the timer holds while its start line is low.
//  - timer_start is 1 in FILL/WASH/DRAIN/RINSE/SPIN/FLUSH and 0 otherwise. It is held continuously
//    across phase changes, so the timer is never re-armed mid-program.
//  - Each tick increments a unit counter (8 bit). When unit count == phase UNITS-1, the next edge
//    changes phase and clears the unit count. Otherwise the count increments.
//  - Sequence: IDLE -start_btn-> FILL -> WASH -> DRAIN -> [FILL -> RINSE -> DRAIN] x RINSES -> SPIN
//    -> DONE -> IDLE. DONE lasts 1 clk and asserts cycle_done.
//  - A rinse counter (4 bit) loads RINSES on IDLE->FILL and decrements on each RINSE->DRAIN.
//    DRAIN goes to FILL if the counter is non-zero, else to SPIN. FILL goes to WASH on the first
//    pass, else to RINSE.
//  - Latency: the first timer period of a program is T+1 clks. Every later period is exactly T clks.
//  - cancel in any timed state (or PAUSE) -> FLUSH. This holds in all cases, including a cycle where
//    a tick is also present. FLUSH: pump_drain=1 and timer_start held until the next tick, so the
//    timer realigns to count 0. Then DRAIN for DRAIN_UNITS, then IDLE with aborted pulsed (no
//    cycle_done). cancel is ignored in IDLE, DONE and FLUSH.
//  - start_btn is ignored outside IDLE. In IDLE, cancel has priority over start_btn (stay IDLE).
//  - Asynchronous reset mid-program returns to IDLE immediately with all actuators off.
// CONFIGURATION
//  WASHER_LID_PAUSE_EN defined:
//   - Adds input lid_open (1 bit), placed after cancel.
//   - lid_open=1 in any timed state except FLUSH -> PAUSE: actuators off, timer_start=0, phase and
//     unit count retained. door_lock stays 1.
//   - lid_open=0 in PAUSE -> resume the saved phase. start_q masks the first cycle after resume.
//   - Same-cycle tick+lid_open: the phase step is taken first, and PAUSE is entered on the next edge.
//   - cancel in PAUSE -> FLUSH.
//  WASHER_LID_PAUSE_EN undefined: no lid_open port, no PAUSE state; state value 8 is unreachable.
// TESTING (bench instantiates the timer with COUNT_MAX=5, default parameters)
//  1. Reset mid-FILL -> next clk all outputs 0, state=0, timer_start=0.
//  2. start_btn 1 clk in IDLE -> states FILL/WASH/DRAIN/FILL/RINSE/DRAIN/SPIN. DONE is entered 56
//     clks after FILL entry, with cycle_done=1 for 1 clk, then IDLE.
//  3. Back-to-back program (start_btn held through DONE) -> second FILL lasts 6 clks (stale done
//     masked), not 1.
//  4. cancel in WASH unit 2 -> FLUSH until tick, DRAIN 5 clks, IDLE with aborted=1, cycle_done=0.
//  5. RINSES=0 -> DRAIN goes directly to SPIN. DONE is entered 36 clks after FILL entry.
//  6. WASHER_LID_PAUSE_EN: lid_open 10 clks in WASH -> motor_wash=0 and state=8 for 10 clks. Total
//     program time extends by 10(+1) clks. Also check tick+lid_open in the same clk.

Source files
------------

// File: rtl/washer_sequencer.sv
// washer_sequencer: wash-program FSM stepping phases on the shared timer's done.
// Optional lid pause, enabled by defining WASHER_LID_PAUSE_EN.
module washer_sequencer #(
  parameter int FILL_UNITS  = 1,
  parameter int WASH_UNITS  = 3,
  parameter int RINSE_UNITS = 2,
  parameter int DRAIN_UNITS = 1,
  parameter int SPIN_UNITS  = 2,
  parameter int RINSES      = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_btn,
  input  logic       cancel,
`ifdef WASHER_LID_PAUSE_EN
  input  logic       lid_open,
`endif
  input  logic       timer_done,
  output logic       timer_start,
  output logic       valve_fill,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       pump_drain,
  output logic       door_lock,
  output logic       busy,
  output logic       cycle_done,
  output logic       aborted,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FILL  = 4'd1;
  localparam logic [3:0] S_WASH  = 4'd2;
  localparam logic [3:0] S_DRAIN = 4'd3;
  localparam logic [3:0] S_RINSE = 4'd4;
  localparam logic [3:0] S_SPIN  = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
`ifdef WASHER_LID_PAUSE_EN
  localparam logic [3:0] S_PAUSE = 4'd8;
`endif

  logic [3:0] r_state;
  logic [7:0] r_unit;
  logic [3:0] r_rinse;
  logic       r_washed;
  logic       r_abort;
  logic       r_start_q;
`ifdef WASHER_LID_PAUSE_EN
  logic [3:0] r_saved;
  logic [3:0] w_nxt_saved;
`endif

  logic [3:0] w_nxt_state;
  logic [7:0] w_nxt_unit;
  logic [3:0] w_nxt_rinse;
  logic       w_nxt_washed;
  logic       w_nxt_abort;
  logic [7:0] w_last;
  logic       w_tick;

  logic w_ts;
  logic w_fill;
  logic w_wash;
  logic w_spin;
  logic w_pump;
  logic w_busy;
  logic w_cd;
  logic w_ab;

  // done is sticky while start is low; only trust it a cycle after start
  assign w_tick = timer_done & r_start_q;
  assign state  = r_state;

  always_comb begin
    w_last = 8'd0;
    case (r_state)
      S_FILL:  w_last = 8'(FILL_UNITS - 1);
      S_WASH:  w_last = 8'(WASH_UNITS - 1);
      S_DRAIN: w_last = 8'(DRAIN_UNITS - 1);
      S_RINSE: w_last = 8'(RINSE_UNITS - 1);
      S_SPIN:  w_last = 8'(SPIN_UNITS - 1);
      default: w_last = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_unit      <= 8'd0;
      r_rinse     <= 4'd0;
      r_washed    <= 1'b0;
      r_abort     <= 1'b0;
      r_start_q   <= 1'b0;
`ifdef WASHER_LID_PAUSE_EN
      r_saved     <= S_IDLE;
`endif
      timer_start <= 1'b0;
      valve_fill  <= 1'b0;
      motor_wash  <= 1'b0;
      motor_spin  <= 1'b0;
      pump_drain  <= 1'b0;
      door_lock   <= 1'b0;
      busy        <= 1'b0;
      cycle_done  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_unit      <= w_nxt_unit;
      r_rinse     <= w_nxt_rinse;
      r_washed    <= w_nxt_washed;
      r_abort     <= w_nxt_abort;
      r_start_q   <= timer_start;
`ifdef WASHER_LID_PAUSE_EN
      r_saved     <= w_nxt_saved;
`endif
      timer_start <= w_ts;
      valve_fill  <= w_fill;
      motor_wash  <= w_wash;
      motor_spin  <= w_spin;
      pump_drain  <= w_pump;
      door_lock   <= w_busy;
      busy        <= w_busy;
      cycle_done  <= w_cd;
      aborted     <= w_ab;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_unit   = r_unit;
    w_nxt_rinse  = r_rinse;
    w_nxt_washed = r_washed;
    w_nxt_abort  = r_abort;
`ifdef WASHER_LID_PAUSE_EN
    w_nxt_saved  = r_saved;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_btn && !cancel) begin
          w_nxt_state  = S_FILL;
          w_nxt_unit   = 8'd0;
          w_nxt_rinse  = 4'(RINSES);
          w_nxt_washed = 1'b0;
          w_nxt_abort  = 1'b0;
        end
      end
      S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
        if (cancel) begin
          w_nxt_state = S_FLUSH;
          w_nxt_unit  = 8'd0;
          w_nxt_abort = 1'b1;
        end else if (w_tick && r_unit != w_last) begin
          w_nxt_unit = r_unit + 8'd1;
        end else if (w_tick) begin
          w_nxt_unit = 8'd0;
          case (r_state)
            S_FILL:
              w_nxt_state = r_washed ? S_RINSE : S_WASH;
            S_WASH: begin
              w_nxt_state  = S_DRAIN;
              w_nxt_washed = 1'b1;
            end
            S_RINSE: begin
              w_nxt_state = S_DRAIN;
              w_nxt_rinse = r_rinse - 4'd1;
            end
            S_DRAIN: begin
              if (r_abort)
                w_nxt_state = S_IDLE;
              else if (r_rinse != 4'd0)
                w_nxt_state = S_FILL;
              else
                w_nxt_state = S_SPIN;
            end
            default: w_nxt_state = S_DONE;
          endcase
        end
`ifdef WASHER_LID_PAUSE_EN
        else if (lid_open) begin
          w_nxt_state = S_PAUSE;
          w_nxt_saved = r_state;
        end
`endif
      end
      S_FLUSH: begin
        if (w_tick) begin
          w_nxt_state = S_DRAIN;
          w_nxt_unit  = 8'd0;
        end
      end
`ifdef WASHER_LID_PAUSE_EN
      S_PAUSE: begin
        if (cancel) begin
          w_nxt_state = S_FLUSH;
          w_nxt_unit  = 8'd0;
          w_nxt_abort = 1'b1;
        end else if (!lid_open) begin
          w_nxt_state = r_saved;
        end
      end
`endif
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ts   = 1'b0;
    w_fill = 1'b0;
    w_wash = 1'b0;
    w_spin = 1'b0;
    w_pump = 1'b0;
    w_cd   = 1'b0;
    case (w_nxt_state)
      S_FILL: begin
        w_ts   = 1'b1;
        w_fill = 1'b1;
      end
      S_WASH, S_RINSE: begin
        w_ts   = 1'b1;
        w_wash = 1'b1;
      end
      S_DRAIN, S_FLUSH: begin
        w_ts   = 1'b1;
        w_pump = 1'b1;
      end
      S_SPIN: begin
        w_ts   = 1'b1;
        w_spin = 1'b1;
      end
      S_DONE:  w_cd = 1'b1;
      default: w_ts = 1'b0;
    endcase
    w_busy = (w_nxt_state != S_IDLE);
    w_ab   = (w_nxt_state == S_IDLE) && (r_state == S_DRAIN) && r_abort;
  end

endmodule
